// File: rtl/sms_pkg.sv
// Shared definitions for the SMS console indicator cards: pull-up input
// resolution, synchronizer depth and lamp-drive polarity.
package sms_pkg;

  localparam int   SYNC_STAGES = 2;
  localparam logic LAMP_ON     = 1'b1;

  // A floating card pin is pulled up, so z reads as 1; anything unknown reads as 0.
  function automatic logic ipu(input logic v);
    return (v === 1'b1) || (v === 1'bz);
  endfunction

endpackage

// File: rtl/sms_sync_fall.sv
// One-bit input conditioner: pull-up resolution, multi-flop synchronizer,
// and a single-cycle pulse on each falling edge of the synchronized level.
module sms_sync_fall
  import sms_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Idle state is high so that a pin already low when reset releases counts as a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ipu(pin)};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign fall  = prev_q & ~level;

endmodule

// File: rtl/sms_card_ind_trigger.sv
// IBM 1620 control indicator trigger card: latches active-low set/clear pulses
// into per-channel triggers and drives the console lamps with blink and lamp test.
module sms_card_ind_trigger
  import sms_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] set_n,
  input  logic [N_CH-1:0] clr_n,
  input  logic [N_CH-1:0] blink_en,
  input  logic            all_clr_n,
  input  logic            lamp_test_n,
  output logic [N_CH-1:0] drv,
  output logic [N_CH-1:0] trig,
  output logic            blink_phase
);

  localparam int              CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [N_CH-1:0]  set_fall;
  logic [N_CH-1:0]  clr_fall;
  logic [N_CH-1:0]  blink_en_lvl;
  logic [N_CH-1:0]  set_lvl_unused;
  logic [N_CH-1:0]  clr_lvl_unused;
  logic [N_CH-1:0]  blink_fall_unused;
  logic             all_clr_lvl;
  logic             lamp_test_lvl;
  logic             all_clr_fall_unused;
  logic             lamp_fall_unused;
  logic [CNT_W-1:0] blink_cnt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sms_sync_fall u_set (
      .clk   (clk),
      .rst   (rst),
      .pin   (set_n[i]),
      .level (set_lvl_unused[i]),
      .fall  (set_fall[i])
    );
    sms_sync_fall u_clr (
      .clk   (clk),
      .rst   (rst),
      .pin   (clr_n[i]),
      .level (clr_lvl_unused[i]),
      .fall  (clr_fall[i])
    );
    sms_sync_fall u_blink (
      .clk   (clk),
      .rst   (rst),
      .pin   (blink_en[i]),
      .level (blink_en_lvl[i]),
      .fall  (blink_fall_unused[i])
    );
  end

  sms_sync_fall u_all_clr (
    .clk   (clk),
    .rst   (rst),
    .pin   (all_clr_n),
    .level (all_clr_lvl),
    .fall  (all_clr_fall_unused)
  );

  sms_sync_fall u_lamp_test (
    .clk   (clk),
    .rst   (rst),
    .pin   (lamp_test_n),
    .level (lamp_test_lvl),
    .fall  (lamp_fall_unused)
  );

  // Clear beats set on the same channel, and a held console check reset beats everything.
  always_ff @(posedge clk) begin
    if (rst || !all_clr_lvl) begin
      trig <= '0;
    end else begin
      trig <= (trig | set_fall) & ~clr_fall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + CNT_W'(1);
    end
  end

  // Lamp test lights every lamp without touching the triggers underneath.
  always_ff @(posedge clk) begin
    if (rst) begin
      drv <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!lamp_test_lvl) begin
          drv[i] <= LAMP_ON;
        end else if (trig[i] && (!blink_en_lvl[i] || blink_phase)) begin
          drv[i] <= LAMP_ON;
        end else begin
          drv[i] <= ~LAMP_ON;
        end
      end
    end
  end

endmodule

// File: tb/tb_sms_card_ind_trigger.sv
// Directed self-checking bench for sms_card_ind_trigger with hand-computed
// expectations and a small edge-count model for the blink phase.
module tb_sms_card_ind_trigger;

  logic       clk;
  logic       rst;
  logic [3:0] set_drv;
  logic [3:0] clr_drv;
  logic [3:0] ben_drv;
  logic       aclr_drv;
  logic       lamp_drv;
  logic       float0;
  logic [3:0] drv;
  logic [3:0] trig;
  logic       blink_phase;

  int total = 0;
  int bad = 0;
  int n_edges = 0;

  // set_n[0] can be released to float so the pull-up path is exercised.
  wire set0_w;
  pullup (set0_w);
  assign set0_w = float0 ? 1'bz : set_drv[0];
  wire [3:0] set_n_bus = {set_drv[3:1], set0_w};

  sms_card_ind_trigger #(.N_CH(4), .BLINK_DIV(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .set_n       (set_n_bus),
    .clr_n       (clr_drv),
    .blink_en    (ben_drv),
    .all_clr_n   (aclr_drv),
    .lamp_test_n (lamp_drv),
    .drv         (drv),
    .trig        (trig),
    .blink_phase (blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] s, input logic [3:0] c,
                               input logic [3:0] b, input logic a, input logic l);
    set_drv  = s;
    clr_drv  = c;
    ben_drv  = b;
    aclr_drv = a;
    lamp_drv = l;
  endtask

  // Advance whole cycles, counting non-reset edges for the blink model.
  task automatic tick(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      logic r;
      r = rst;
      @(posedge clk);
      if (r) n_edges = 0;
      else n_edges++;
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_phase;
    logic prev_phase;

    float0 = 1'b0;
    rst    = 1'b1;
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b1, 1'b1);
    tick(2);
    checkOutput("reset_trig", 32'(trig), 32'h0);
    checkOutput("reset_drv", 32'(drv), 32'h0);
    checkOutput("reset_phase", 32'(blink_phase), 32'h0);
    rst = 1'b0;
    tick(9);

    $display("[TB] single set on channel 0");
    applyStimulus(4'hE, 4'hF, 4'h0, 1'b1, 1'b1);
    tick(2);
    checkOutput("set0_k1_trig", 32'(trig), 32'h0);
    tick(1);
    checkOutput("set0_k2_trig", 32'(trig), 32'h1);
    checkOutput("set0_k2_drv", 32'(drv), 32'h0);
    tick(1);
    checkOutput("set0_k3_drv", 32'(drv), 32'h1);
    applyStimulus(4'hE, 4'hE, 4'h0, 1'b1, 1'b1);
    tick(1);
    applyStimulus(4'hE, 4'hF, 4'h0, 1'b1, 1'b1);
    tick(2);
    checkOutput("clr0_trig", 32'(trig), 32'h0);
    tick(4);
    checkOutput("set0_held_no_retrigger", 32'(trig), 32'h0);
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b1, 1'b1);
    tick(3);

    $display("[TB] clear priority on channel 1");
    applyStimulus(4'hD, 4'hF, 4'h0, 1'b1, 1'b1);
    tick(1);
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b1, 1'b1);
    tick(2);
    checkOutput("set1_trig", 32'(trig), 32'h2);
    applyStimulus(4'hD, 4'hD, 4'h0, 1'b1, 1'b1);
    tick(1);
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b1, 1'b1);
    tick(1);
    checkOutput("setclr1_k1_trig", 32'(trig), 32'h2);
    tick(1);
    checkOutput("setclr1_k2_trig", 32'(trig), 32'h0);
    tick(2);

    $display("[TB] console check reset");
    applyStimulus(4'h0, 4'hF, 4'h0, 1'b1, 1'b1);
    tick(1);
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b1, 1'b1);
    tick(2);
    checkOutput("setall_trig", 32'(trig), 32'hF);
    tick(1);
    checkOutput("setall_drv", 32'(drv), 32'hF);
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b1, 1'b1);
    tick(1);
    checkOutput("allclr_k1_trig", 32'(trig), 32'hF);
    tick(1);
    checkOutput("allclr_k2_trig", 32'(trig), 32'h0);
    checkOutput("allclr_k2_drv", 32'(drv), 32'hF);
    tick(1);
    checkOutput("allclr_k3_drv", 32'(drv), 32'h0);
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b0, 1'b1);
    tick(3);
    applyStimulus(4'hB, 4'hF, 4'h0, 1'b0, 1'b1);
    tick(1);
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b0, 1'b1);
    tick(3);
    checkOutput("allclr_blocks_set2", 32'(trig), 32'h0);
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b1, 1'b1);
    tick(3);
    checkOutput("allclr_release_trig", 32'(trig), 32'h0);

    $display("[TB] lamp test");
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b1, 1'b0);
    tick(2);
    checkOutput("lamp_k1_drv", 32'(drv), 32'h0);
    tick(1);
    checkOutput("lamp_k2_drv", 32'(drv), 32'hF);
    checkOutput("lamp_k2_trig", 32'(trig), 32'h0);
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b1, 1'b1);
    tick(2);
    checkOutput("lamp_rel_k1_drv", 32'(drv), 32'hF);
    tick(1);
    checkOutput("lamp_rel_k2_drv", 32'(drv), 32'h0);

    $display("[TB] blink on channel 3");
    applyStimulus(4'h7, 4'hF, 4'h8, 1'b1, 1'b1);
    tick(1);
    applyStimulus(4'hF, 4'hF, 4'h8, 1'b1, 1'b1);
    tick(3);
    checkOutput("blink_trig", 32'(trig), 32'h8);
    for (int c = 0; c < 32; c++) begin
      tick(1);
      exp_phase  = ((n_edges / 8) % 2) == 1;
      prev_phase = (((n_edges - 1) / 8) % 2) == 1;
      checkOutput("blink_phase", 32'(blink_phase), 32'(exp_phase));
      checkOutput("blink_drv", 32'(drv), 32'({prev_phase, 3'b000}));
    end
    applyStimulus(4'hF, 4'h7, 4'h0, 1'b1, 1'b1);
    tick(1);
    applyStimulus(4'hF, 4'hF, 4'h0, 1'b1, 1'b1);
    tick(4);
    checkOutput("blink_cleared_trig", 32'(trig), 32'h0);
    checkOutput("blink_cleared_drv", 32'(drv), 32'h0);

    $display("[TB] floating set_n[0]");
    float0 = 1'b1;
    tick(20);
    checkOutput("float_trig", 32'(trig), 32'h0);
    checkOutput("float_drv", 32'(drv), 32'h0);
    float0 = 1'b0;
    tick(2);

    $display("[TB] reset while set_n[0] held low");
    applyStimulus(4'hE, 4'hF, 4'h0, 1'b1, 1'b1);
    tick(4);
    checkOutput("prereset_trig", 32'(trig), 32'h1);
    rst = 1'b1;
    tick(1);
    checkOutput("midreset_trig", 32'(trig), 32'h0);
    checkOutput("midreset_drv", 32'(drv), 32'h0);
    checkOutput("midreset_phase", 32'(blink_phase), 32'h0);
    tick(1);
    rst = 1'b0;
    tick(2);
    checkOutput("postreset_k1_trig", 32'(trig), 32'h0);
    tick(1);
    checkOutput("postreset_k2_trig", 32'(trig), 32'h1);
    tick(5);
    checkOutput("postreset_hold_trig", 32'(trig), 32'h1);
    applyStimulus(4'hE, 4'hE, 4'h0, 1'b1, 1'b1);
    tick(1);
    applyStimulus(4'hE, 4'hF, 4'h0, 1'b1, 1'b1);
    tick(2);
    checkOutput("postreset_clr_trig", 32'(trig), 32'h0);
    tick(5);
    checkOutput("postreset_single_event", 32'(trig), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
